msg_schedule: RTL and testbench
===============================

// Module: msg_schedule
// PURPOSE
//  Downstream of the padding preprocessor. Expands each padded 512-bit block into the
//  64-word SHA-256 message schedule W[0..63], one word per accepted handshake.
//  Uses a 16-word sliding window. Feeds the compression round core.
//  Streams up to NUM_BLOCKS blocks back-to-back, first block = most-significant slot.
// PARAMETERS
//  NUM_BLOCKS  2   max blocks per message; size of msg_in and of block_idx range
// PORTS
//  clk          in   1                 clock
//  n_rst        in   1                 reset: asynchronous, active-low
//  start        in   1                 pulse: latch msg_in/position, begin expansion
//  msg_in       in   [NUM_BLOCKS-1:0][511:0]  padded blocks; slot [position] is first
//  position     in   $clog2(NUM_BLOCKS) index of first block (= block count - 1)
//  word_out     out  32                current W[word_idx]
//  word_valid   out  1                 word_out valid
//  word_ready   in   1                 consumer accepts word this cycle
//  word_idx     out  6                 schedule index t of word_out (0..63)
//  block_idx    out  $clog2(NUM_BLOCKS) blocks completed before the current one (0 = first)
//  last_block   out  1                 current block is final block of message
//  busy         out  1                 high in EXPAND and DONE
//  done         out  1                 one-cycle pulse after final W[63] transfer
// BEHAVIOUR
//  Reset: state IDLE; window, counters, latched message cleared.
//  Reset: all outputs 0.
//  FSM states:
//   IDLE: on start, load window w[i] = slot[position] word i (w[0] = bits 511:480).
//    Set word_idx=0, remaining=position, then go to EXPAND.
//   EXPAND: word_valid=1, word_out=w[0].
//   DONE: done=1 for one cycle, then IDLE.
//  Latency: start at cycle N -> word_valid with W[0] at cycle N+1.
//  Transfer = word_valid & word_ready. On transfer:
//   shift w[i]=w[i+1].
//   w[15] = sig1(w[14]) + w[9] + sig0(w[1]) + w[0]  (mod 2^32).
//   word_idx increments.
//  sig0(x) = ROTR7 ^ ROTR18 ^ SHR3; sig1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//  Stall: word_ready=0 holds word_out, word_idx and block_idx stable; valid stays high.
//  Transfer at word_idx=63:
//   If remaining!=0: load window from slot[remaining-1], word_idx=0, block_idx++,
//    remaining--. No bubble: next block's W[0] is valid the next cycle.
//   Else: go to DONE.
//  last_block = (remaining==0).
//  position >= NUM_BLOCKS is clamped to NUM_BLOCKS-1.
//  start outside IDLE is ignored; msg_in is sampled only on accepted start.
//  Reset mid-expansion aborts immediately. No done pulse is emitted.
//  The 64th-word sliding-window update is don't-care (window is reloaded or discarded).
// CONFIGURATION
//  MSG_SCHED_BYTESWAP_EN defined:
//   Each 32-bit word is byte-reversed at window load (little-endian header input).
//   Byte-reversal applies to loads on start and on block change.
//  MSG_SCHED_BYTESWAP_EN undefined: words loaded big-endian as-is.
//  Expansion arithmetic identical in both builds.
// STRUCTURE
//  sha256_pkg (shared with compression core):
//   word_t (logic [31:0]).
//   state enum {IDLE, EXPAND, DONE}.
//   functions sig0/sig1/bswap32.
//   localparam ROUNDS=64, WINDOW=16.
//  Sub-module sha256_sched_step: combinational, 4 words in -> new window word.
//  sha256_sched_step is reused by the compression core's lookahead.
// TESTING
//  1. "abc" padded block, position=0, word_ready=1:
//   W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
//   64 transfers, then done pulse 1 cycle after W63.
//  2. Two blocks (position=1), ready=1:
//   128 consecutive valid cycles, no bubble.
//   block_idx 0->1 at the 65th word; last_block=1 only in second block.
//  3. Backpressure: word_ready toggles 1,0,0,1 during block 1.
//   word_out/word_idx frozen while ready=0.
//   Sequence identical to test 1; done delayed by the stall count.
//  4. start pulsed mid-expansion with different msg_in: ignored.
//   Outputs unchanged; next start in IDLE is accepted.
//  5. n_rst asserted at word_idx=30:
//   All outputs 0 next edge, no done pulse.
//   Fresh start reproduces test 1 exactly.
//  6. MSG_SCHED_BYTESWAP_EN build, "abc" block: W0=0x80636261.
//   W16=W0+sig0(W1)+sig1(W14)+W9 with swapped words, checked against the reference model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and helpers for the message schedule and the compression core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam int unsigned ROUNDS = 64;
  localparam int unsigned WINDOW = 16;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t bswap32(input word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Word stream from the message schedule to the compression round core.
interface msg_schedule_if #(
  parameter int unsigned NUM_BLOCKS = 2
);
  localparam int unsigned BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  logic [31:0]   word_out;
  logic          word_valid;
  logic          word_ready;
  logic [5:0]    word_idx;
  logic [BW-1:0] block_idx;
  logic          last_block;

  modport master (
    output word_out, word_valid, word_idx, block_idx, last_block,
    input  word_ready
  );

  modport slave (
    input  word_out, word_valid, word_idx, block_idx, last_block,
    output word_ready
  );
endinterface

// File: rtl/sha256_sched_step.sv
// One message-schedule recurrence step: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_sched_step
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_new
);
  assign w_new = sig1(w14) + w9 + sig0(w1) + w0;
endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: streams W[0..63] for each of up to NUM_BLOCKS blocks.
// Build option MSG_SCHED_BYTESWAP_EN byte-reverses every word as it is loaded.
module msg_schedule
  import sha256_pkg::*;
#(
  parameter  int unsigned NUM_BLOCKS = 2,
  localparam int unsigned BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic [NUM_BLOCKS-1:0][511:0] msg_in,
  input  logic [BW-1:0]               position,
  msg_schedule_if.master              ws,
  output logic                        busy,
  output logic                        done
);

  state_t                        state, state_nx;
  word_t                         win [WINDOW];
  word_t                         w_new;
  logic [NUM_BLOCKS-1:0][511:0]  msg_q;
  logic [BW-1:0]                 remaining;
  logic [BW-1:0]                 next_slot;
  logic [BW-1:0]                 pos_c;
  logic [5:0]                    idx;
  logic [BW-1:0]                 blk;
  logic                          xfer;
  logic                          last_word;

  function automatic word_t load_word(input logic [511:0] b, input int unsigned i);
    word_t w;
    w = b[511 - 32*i -: 32];
`ifdef MSG_SCHED_BYTESWAP_EN
    return bswap32(w);
`else
    return w;
`endif
  endfunction

  assign pos_c     = (position > BW'(NUM_BLOCKS - 1)) ? BW'(NUM_BLOCKS - 1) : position;
  assign next_slot = remaining - BW'(1);
  assign xfer      = (state == EXPAND) && ws.word_ready;
  assign last_word = (idx == 6'(ROUNDS - 1));

  sha256_sched_step u_step (
    .w0   (win[0]),
    .w1   (win[1]),
    .w9   (win[9]),
    .w14  (win[14]),
    .w_new(w_new)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = EXPAND;
      EXPAND: begin
        busy = 1'b1;
        if (xfer && last_word && remaining == '0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Block change reloads the window in the same cycle as W[63] leaves, so there is no bubble.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < WINDOW; i++) win[i] <= '0;
      msg_q     <= '0;
      remaining <= '0;
      idx       <= '0;
      blk       <= '0;
    end else if (state == IDLE && start) begin
      msg_q <= msg_in;
      for (int unsigned i = 0; i < WINDOW; i++) win[i] <= load_word(msg_in[pos_c], i);
      remaining <= pos_c;
      idx       <= '0;
      blk       <= '0;
    end else if (xfer) begin
      if (last_word && remaining != '0) begin
        for (int unsigned i = 0; i < WINDOW; i++) win[i] <= load_word(msg_q[next_slot], i);
        remaining <= next_slot;
        idx       <= '0;
        blk       <= blk + BW'(1);
      end else begin
        for (int unsigned i = 0; i < WINDOW - 1; i++) win[i] <= win[i+1];
        win[WINDOW-1] <= w_new;
        idx           <= idx + 6'd1;
      end
    end
  end

  assign ws.word_valid = (state == EXPAND);
  assign ws.word_out   = (state == EXPAND) ? win[0] : '0;
  assign ws.word_idx   = idx;
  assign ws.block_idx  = blk;
  assign ws.last_block = (state == EXPAND) && (remaining == '0);

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule against a whole-array SHA-256 schedule model.
module tb_msg_schedule;

  localparam int unsigned NB = 2;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 start = 1'b0;
  logic [NB-1:0][511:0] msg_in = '0;
  logic [0:0]           position = '0;
  logic                 busy, done;

  msg_schedule_if #(.NUM_BLOCKS(NB)) sif();

  msg_schedule #(.NUM_BLOCKS(NB)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .msg_in  (msg_in),
    .position(position),
    .ws      (sif.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_w [0:127];
  logic [31:0] got   [0:127];

  typedef struct {
    string       name;
    int          t;
    logic [31:0] w;
  } vec_t;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] blk_word(input logic [511:0] b, input int i);
    logic [31:0] w;
    w = b[511 - 32*i -: 32];
`ifdef MSG_SCHED_BYTESWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
    return b;
  endfunction

  // Full 64-entry schedule per block, first block taken from slot[pos].
  task automatic build_model(input logic [NB-1:0][511:0] m, input int pos);
    logic [31:0] w [0:63];
    for (int b = 0; b <= pos; b++) begin
      for (int t = 0; t < 16; t++) w[t] = blk_word(m[pos - b], t);
      for (int t = 16; t < 64; t++)
        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
      for (int t = 0; t < 64; t++) exp_w[b*64 + t] = w[t];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run(input logic [NB-1:0][511:0] m, input int pos, input int mode,
                     input int inject_at);
    int          nt, k, s, bubbles, stalls;
    logic        pv, rdy;
    logic [31:0] pw;
    logic [5:0]  pidx;
    logic        pblk;
    logic [3:0]  pat;
    nt = 64 * (pos + 1);
    k = 0; s = 0; bubbles = 0; stalls = 0; pv = 1'b0;
    pw = '0; pidx = '0; pblk = 1'b0;
    pat = 4'b1001;
    build_model(m, pos);
    msg_in   = m;
    position = 1'(pos);
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", 64'(sif.word_valid), 64'd1);
    for (int guard = 0; guard < 2000 && k < nt; guard++) begin
      s++;
      if (pv)
        chk("stall_hold", 64'({sif.word_out, sif.word_idx, sif.block_idx}),
            64'({pw, pidx, pblk}));
      if (!sif.word_valid) bubbles++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[s % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.word_ready = rdy;
      if (s == inject_at) begin
        msg_in = ~m;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      pv = 1'b0;
      if (sif.word_valid && rdy) begin
        chk($sformatf("word[%0d]", k),
            64'({sif.word_out, sif.word_idx, sif.block_idx, sif.last_block}),
            64'({exp_w[k], 6'(k % 64), 1'(k / 64), 1'((k / 64) == pos)}));
        got[k] = sif.word_out;
        k++;
      end else if (sif.word_valid) begin
        stalls++;
        pv   = 1'b1;
        pw   = sif.word_out;
        pidx = sif.word_idx;
        pblk = sif.block_idx;
      end
      tick();
    end
    start = 1'b0;
    chk("transfer_count", 64'(k), 64'(nt));
    chk("no_bubble", 64'(bubbles), 64'd0);
    chk("done_timing", 64'(s), 64'(nt + stalls));
    chk("done_pulse", 64'({done, busy, sif.word_valid}), 64'(3'b110));
    tick();
    chk("done_clear", 64'({done, busy}), 64'd0);
    sif.word_ready = 1'b0;
    msg_in = m;
  endtask

  logic [NB-1:0][511:0] abc;
  logic [NB-1:0][511:0] m2;
  vec_t                 tab [4];

  initial begin
    sif.word_ready = 1'b0;
    abc = '0;
    abc[0] = {32'h61626380, 416'h0, 64'h18};

`ifdef MSG_SCHED_BYTESWAP_EN
    tab[0] = '{"abc_W0",  0,  32'h80636261};
    tab[1] = '{"abc_W15", 15, 32'h18000000};
    tab[2] = '{"abc_W16", 16, 32'h80636261};
    tab[3] = '{"abc_W17", 17, 32'h00060F00};
`else
    tab[0] = '{"abc_W0",  0,  32'h61626380};
    tab[1] = '{"abc_W15", 15, 32'h00000018};
    tab[2] = '{"abc_W16", 16, 32'h61626380};
    tab[3] = '{"abc_W17", 17, 32'h000F0000};
`endif

    #3;
    chk("reset_outputs", 64'({sif.word_out, sif.word_valid, sif.word_idx, sif.block_idx,
                              sif.last_block, busy, done}), 64'd0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("idle_outputs", 64'({sif.word_valid, busy, done, sif.last_block}), 64'd0);

    // Single "abc" block, then the known-value table.
    run(abc, 0, 0, -1);
    for (int i = 0; i < 4; i++) chk(tab[i].name, 64'(got[tab[i].t]), 64'(tab[i].w));

    // Two blocks back to back.
    m2 = '0;
    m2[1] = rand_blk();
    m2[0] = abc[0];
    run(m2, 1, 0, -1);

    // Backpressure.
    run(abc, 0, 1, -1);

    // start with different data mid-expansion is ignored; the next start is accepted.
    run(abc, 0, 0, 20);
    m2[0] = rand_blk();
    run(m2, 0, 0, -1);

    // Reset at word_idx 30 aborts without a done pulse.
    msg_in = abc; position = 1'b0; start = 1'b1;
    sif.word_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 100 && sif.word_idx != 6'd30; g++) tick();
    chk("abort_reached_30", 64'(sif.word_idx), 64'd30);
    n_rst = 1'b0;
    #1;
    chk("abort_outputs", 64'({sif.word_out, sif.word_valid, sif.word_idx, sif.block_idx,
                              sif.last_block, busy, done}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 64'({done, busy}), 64'd0);
    end
    #2;
    n_rst = 1'b1;
    sif.word_ready = 1'b0;
    tick();
    run(abc, 0, 0, -1);
    for (int i = 0; i < 4; i++) chk(tab[i].name, 64'(got[tab[i].t]), 64'(tab[i].w));

    // Randomized messages, positions and ready patterns.
    for (int it = 0; it < 4; it++) begin
      m2[1] = rand_blk();
      m2[0] = rand_blk();
      run(m2, int'($urandom_range(0, 1)), 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
